router_ctrl_fsm: RTL

Parametrised packet-routing controller for the 1xN router. Generalises the 3-port controller to `NUM_PORTS` destinations. It latches the header's destination and tracks only that FIFO's empty/full/soft-reset status. Packets with an out-of-range address are discarded in a dedicated drop state, and the header-wait can optionally time out. It sits between the register block (consumes its strobes) and the FIFO bank/synchroniser (consumes their status vectors).

---
 rtl/router_ctrl_fsm.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/router_ctrl_fsm.sv
// Purpose: packet-routing controller for a 1xNUM_PORTS router; latches the header destination and
//          sequences header/payload/parity writes into that channel's FIFO.
// Latency: header accepted at edge N -> lfd_state in cycle N+1, ld_state in cycle N+2.
// Backpressure: busy stalls the source while waiting/loading; full FIFO parks in FIFO_FULL_STATE.
// Ports:
//   clock, resetn                                  - clock, synchronous active-low reset
//   pkt_valid, data_in                             - source valid and header address bits
//   fifo_empty_vec/fifo_full_vec/soft_reset_vec    - per-channel status from FIFO bank/synchroniser
//   parity_done, low_packet_valid                  - strobes from the register block
//   dest_sel                                       - latched destination channel
//   detect_add..drop_state, write_enb_reg, busy    - Moore decodes of the present state
//   fifo_full                                      - full flag of the selected channel
// Option: define ROUTER_CTRL_WAIT_TIMEOUT_EN to abandon WAIT_TILL_EMPTY after WAIT_MAX cycles.
module router_ctrl_fsm #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2,
  parameter int WAIT_MAX  = 30
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] fifo_empty_vec,
  input  logic [NUM_PORTS-1:0] fifo_full_vec,
  input  logic [NUM_PORTS-1:0] soft_reset_vec,
  input  logic                 parity_done,
  input  logic                 low_packet_valid,
  output logic [ADDR_W-1:0]    dest_sel,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 drop_state,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic                 fifo_full
);

  localparam int SEL_N = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PORTS_LIM = (ADDR_W+1)'(NUM_PORTS);

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    WAIT_TILL_EMPTY    = 4'd2,
    LOAD_DATA          = 4'd3,
    LOAD_PARITY        = 4'd4,
    FIFO_FULL_STATE    = 4'd5,
    LOAD_AFTER_FULL    = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PACKET        = 4'd8
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dest_q, dest_d;

  // Status vectors widened to the full address space so any address indexes a real bit;
  // the padding bits are never selected because out-of-range headers go to DROP_PACKET.
  logic [SEL_N-1:0] empty_ext, full_ext, srst_ext;

  always_comb begin
    empty_ext = '0;
    full_ext  = '0;
    srst_ext  = '0;
    empty_ext[NUM_PORTS-1:0] = fifo_empty_vec;
    full_ext[NUM_PORTS-1:0]  = fifo_full_vec;
    srst_ext[NUM_PORTS-1:0]  = soft_reset_vec;
  end

  logic hdr_in_range;
  logic wait_expired;

  assign hdr_in_range = ({1'b0, data_in} < PORTS_LIM);
  assign fifo_full    = full_ext[dest_q];

`ifdef ROUTER_CTRL_WAIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  // cnt_q holds (WAIT cycles already spent); it reads WAIT_MAX-1 on the WAIT_MAX-th cycle.
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wait_expired = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == WAIT_TILL_EMPTY) cnt_d = cnt_q + CNT_W'(1);
    if (state_d == WAIT_TILL_EMPTY && state_q != WAIT_TILL_EMPTY) cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_wait_max;
  assign unused_wait_max = ^WAIT_MAX;
  assign wait_expired    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    unique case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          if (!hdr_in_range) begin
            state_d = DROP_PACKET;
          end else begin
            dest_d  = data_in;
            state_d = empty_ext[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      WAIT_TILL_EMPTY: begin
        // Empty on the last allowed cycle still wins over the timeout.
        if (empty_ext[dest_q])  state_d = LOAD_FIRST_DATA;
        else if (wait_expired)  state_d = DROP_PACKET;
      end
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      LOAD_PARITY:     state_d = CHECK_PARITY_ERROR;
      FIFO_FULL_STATE: if (!fifo_full) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)           state_d = DECODE_ADDRESS;
        else if (low_packet_valid) state_d = LOAD_PARITY;
        else                       state_d = LOAD_DATA;
      end
      CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      DROP_PACKET:        if (!pkt_valid) state_d = DECODE_ADDRESS;
      default:            state_d = DECODE_ADDRESS;
    endcase

    // Soft reset of the selected channel aborts the packet; idle decode ignores it.
    if (state_q != DECODE_ADDRESS && srst_ext[dest_q]) state_d = DECODE_ADDRESS;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  assign dest_sel      = dest_q;
  assign detect_add    = (state_q == DECODE_ADDRESS);
  assign lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign ld_state      = (state_q == LOAD_DATA);
  assign laf_state     = (state_q == LOAD_AFTER_FULL);
  assign full_state    = (state_q == FIFO_FULL_STATE);
  assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign drop_state    = (state_q == DROP_PACKET);
  assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                         (state_q == LOAD_AFTER_FULL);
  // busy stays low in DROP_PACKET so the source can drain the discarded packet.
  assign busy          = (state_q == LOAD_FIRST_DATA) || (state_q == WAIT_TILL_EMPTY) ||
                         (state_q == LOAD_PARITY) || (state_q == FIFO_FULL_STATE) ||
                         (state_q == LOAD_AFTER_FULL) || (state_q == CHECK_PARITY_ERROR);

endmodule
